dsp_frame_acc: RTL and testbench
================================

Name: dsp_frame_acc

Overview:
Downstream stage of the DSP pre-add/multiply/post-add slice. Qualifies the slice's raw 48-bit p output with a latency-matched valid and accumulates a programmable-length frame of p samples into a signed saturating sum. Completed frame sums pass through a small output FIFO to the consumer with a valid/ready handshake.

Parameters:
P_WIDTH, 48, width of the signed p input.
LATENCY, 4, cycles from operand issue into the DSP slice until the matching p is valid.
LEN_WIDTH, 8, width of frame_len.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, at least 2.

Ports:
clk  input  1  clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
issue  input  1  pulse: operands presented to the DSP slice this cycle.
p  input  P_WIDTH  signed product/sum from the DSP slice.
frame_len  input  LEN_WIDTH  samples per frame; 0 is treated as 1.
m_data  output  P_WIDTH  signed frame sum at the FIFO head.
m_ovf  output  1  head entry's sum saturated.
m_valid  output  1  FIFO not empty.
m_ready  input  1  consumer accepts the head entry.
busy  output  1  frame in progress, or any issue still in flight in the delay line.
drop_err  output  1  sticky: a completed frame was lost because the FIFO was full.

Behaviour:
- Reset (async, rst_n low): delay line, accumulator, count, state, FIFO pointers and drop_err all clear to 0. m_valid=0, m_data=0, m_ovf=0, busy=0. Issues in flight are discarded.
- Valid alignment: LATENCY-deep shift register carries issue.
  - sample_valid = issue delayed by exactly LATENCY cycles.
  - p is used only in cycles where sample_valid=1.
  - Back-to-back issue on every cycle is supported.
- FSM, two states:
  - IDLE: on sample_valid, latch len = max(frame_len,1), set acc = p, count = 1, and go to ACC. If len==1, push acc to the FIFO on the same edge and stay in IDLE.
  - ACC: on sample_valid, acc = sat(acc + p) and count += 1. When count reaches len, push the result on that edge, clear count, and return to IDLE. frame_len is ignored while in ACC.
- Arithmetic:
  - The sum is computed at P_WIDTH+1 bits.
  - Results above 2^(P_WIDTH-1)-1 clamp to that maximum; results below -2^(P_WIDTH-1) clamp to that minimum.
  - Any clamp within a frame sets the frame's ovf bit. The bit travels with the entry and clears for the next frame.
- Latency: the sum for the frame's last sample is visible on m_data with m_valid=1 in the cycle after that sample's sample_valid. Issue of the last operands to m_valid = LATENCY+1 cycles.
- FIFO:
  - m_data and m_ovf come from the head entry.
  - Pop on m_valid && m_ready.
  - Push while full: the entry is dropped and drop_err sets, remaining 1 until reset. The FIFO contents are unchanged.
  - Simultaneous push and pop while full: both happen, no drop.
  - Pop while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - m_data is stable while m_valid && !m_ready.
- busy = (state==ACC) OR any delay-line bit set.

Test Plan:
- Basic frame: frame_len=3; issue 3 consecutive cycles with p arriving 10, 20, -5 -> m_valid rises LATENCY+1 cycles after the 3rd issue, m_data=25, m_ovf=0.
- Length 0/1: frame_len=0; p=7 then p=-9, both issued -> two FIFO entries, 7 then -9, each with m_ovf=0.
- Saturation: frame_len=2; p=2^47-1 then p=5 -> m_data=2^47-1, m_ovf=1. Next frame 1+1 -> m_data=2, m_ovf=0.
- Backpressure/overflow: m_ready=0, frame_len=1; 5 issues with p=1..5 -> FIFO holds 1..4 and drop_err=1. Raise m_ready -> pops 1, 2, 3, 4 in order, then m_valid=0.
- Full push+pop: FIFO full, m_ready=1 in the exact cycle a frame completes -> no drop, drop_err stays 0, order preserved.
- Mid-frame reset and len change: frame_len=4, 2 samples accepted, change frame_len to 2 -> frame still needs 4 samples. Assert rst_n=0 mid-frame with 2 issues in flight -> m_valid=0, busy=0, and the next frame starts clean with no stale samples.

Source files
------------

// File: rtl/dsp_frame_acc.sv
// ---------------------------------------------------------------------------
// dsp_frame_acc
//
// Purpose:
//   Sits behind the DSP pre-add/multiply/post-add slice. A valid strobe that
//   travels alongside the slice pipeline marks which p samples are real. Real
//   samples are summed, with signed saturation, over a programmable frame
//   length. Each completed frame sum is queued in a small FIFO and handed to
//   the consumer over a valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   issue      in   operands entered the DSP slice this cycle
//   p          in   signed slice output, meaningful LATENCY cycles after issue
//   frame_len  in   samples per frame (0 behaves as 1), latched at frame start
//   m_data     out  signed frame sum at the FIFO head (0 when empty)
//   m_ovf      out  the head frame saturated at least once
//   m_valid    out  FIFO holds at least one frame sum
//   m_ready    in   consumer takes the head entry this cycle
//   busy       out  a frame is open or an issue is still inside the slice
//   drop_err   out  sticky: a finished frame found the FIFO full and was lost
// ---------------------------------------------------------------------------
module dsp_frame_acc #(
    parameter int P_WIDTH    = 48,
    parameter int LATENCY    = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue,
    input  logic signed [P_WIDTH-1:0]   p,
    input  logic        [LEN_WIDTH-1:0] frame_len,
    output logic signed [P_WIDTH-1:0]   m_data,
    output logic                        m_ovf,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        busy,
    output logic                        drop_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Saturation helpers. The sum arrives one bit wider than the result; the
    // top two bits disagree exactly when the true value left the P_WIDTH range.
    // -----------------------------------------------------------------------
    function automatic logic sat_hit(input logic signed [P_WIDTH:0] s);
        return s[P_WIDTH] ^ s[P_WIDTH-1];
    endfunction

    function automatic logic signed [P_WIDTH-1:0] sat_sum(input logic signed [P_WIDTH:0] s);
        logic signed [P_WIDTH-1:0] r;
        if (s[P_WIDTH] ^ s[P_WIDTH-1]) begin
            // Sign of the wide result tells which rail was crossed.
            r = s[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                           : {1'b0, {(P_WIDTH-1){1'b1}}};
        end else begin
            r = s[P_WIDTH-1:0];
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Stage p0: valid alignment with the slice pipeline
    // -----------------------------------------------------------------------
    logic [LATENCY-1:0] vld_dly;
    logic               vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_dly <= '0;
        end else begin
            vld_dly[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                vld_dly[i] <= vld_dly[i-1];
            end
        end
    end

    assign vld_p0 = vld_dly[LATENCY-1];

    // -----------------------------------------------------------------------
    // Stage p1: frame accumulator and control FSM
    // -----------------------------------------------------------------------
    state_t                     state_p1;
    logic signed [P_WIDTH-1:0]  acc_p1;
    logic                       ovf_p1;
    logic [LEN_WIDTH-1:0]       cnt_p1;
    logic [LEN_WIDTH-1:0]       len_p1;

    logic signed [P_WIDTH:0]    sum_p0;
    logic signed [P_WIDTH-1:0]  sum_sat_p0;
    logic                       sum_hit_p0;
    logic [LEN_WIDTH-1:0]       len_eff;
    logic [LEN_WIDTH-1:0]       cnt_next;
    logic                       last_p0;

    // Sign-extend both operands one bit so the add itself never wraps.
    assign sum_p0     = $signed({acc_p1[P_WIDTH-1], acc_p1}) + $signed({p[P_WIDTH-1], p});
    assign sum_sat_p0 = sat_sum(sum_p0);
    assign sum_hit_p0 = sat_hit(sum_p0);

    assign len_eff  = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
    assign cnt_next = cnt_p1 + LEN_WIDTH'(1);
    assign last_p0  = (cnt_next == len_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            acc_p1   <= '0;
            ovf_p1   <= 1'b0;
            cnt_p1   <= '0;
            len_p1   <= '0;
        end else if (vld_p0) begin
            case (state_p1)
                IDLE: begin
                    // First sample opens the frame; its length is frozen here.
                    acc_p1 <= p;
                    ovf_p1 <= 1'b0;
                    len_p1 <= len_eff;
                    if (len_eff == LEN_WIDTH'(1)) begin
                        cnt_p1   <= '0;
                        state_p1 <= IDLE;
                    end else begin
                        cnt_p1   <= LEN_WIDTH'(1);
                        state_p1 <= ACC;
                    end
                end
                ACC: begin
                    acc_p1 <= sum_sat_p0;
                    ovf_p1 <= ovf_p1 | sum_hit_p0;
                    if (last_p0) begin
                        cnt_p1   <= '0;
                        state_p1 <= IDLE;
                    end else begin
                        cnt_p1   <= cnt_next;
                    end
                end
                default: begin
                    state_p1 <= IDLE;
                end
            endcase
        end
    end

    // The frame result is pushed on the same edge that finishes it, so the
    // FIFO takes the next-state value rather than waiting on acc_p1.
    logic                      push_p0;
    logic signed [P_WIDTH-1:0] push_data_p0;
    logic                      push_ovf_p0;

    always_comb begin
        push_p0      = 1'b0;
        push_data_p0 = '0;
        push_ovf_p0  = 1'b0;
        if (vld_p0) begin
            if (state_p1 == IDLE) begin
                if (len_eff == LEN_WIDTH'(1)) begin
                    push_p0      = 1'b1;
                    push_data_p0 = p;
                end
            end else if (last_p0) begin
                push_p0      = 1'b1;
                push_data_p0 = sum_sat_p0;
                push_ovf_p0  = ovf_p1 | sum_hit_p0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage p2: output FIFO
    // -----------------------------------------------------------------------
    logic signed [P_WIDTH-1:0] mem_data_p2 [FIFO_DEPTH];
    logic                      mem_ovf_p2  [FIFO_DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      pop;
    logic                      wr_en;

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && m_ready;
    // A pop on the same edge frees the slot the push is about to use.
    assign wr_en      = push_p0 && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data_p2[wr_ptr[AW-1:0]] <= push_data_p0;
            mem_ovf_p2[wr_ptr[AW-1:0]]  <= push_ovf_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_err <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_p0 && fifo_full && !pop) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0   : mem_data_p2[rd_ptr[AW-1:0]];
    assign m_ovf   = fifo_empty ? 1'b0 : mem_ovf_p2[rd_ptr[AW-1:0]];

    assign busy = (state_p1 == ACC) || (|vld_dly);

endmodule

// File: tb/tb_dsp_frame_acc.sv
module tb_dsp_frame_acc;

    localparam int PW  = 48;
    localparam int LAT = 4;
    localparam int LW  = 8;
    localparam int FD  = 4;

    localparam logic signed [PW-1:0] PMAX = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [PW-1:0] PMIN = 48'sh8000_0000_0000;
    localparam logic signed [PW-1:0] JUNK = 48'sh5A5A_5A5A_5A5A;

    logic                  clk;
    logic                  rst_n;
    logic                  issue;
    logic signed [PW-1:0]  p;
    logic [LW-1:0]         frame_len;
    logic signed [PW-1:0]  m_data;
    logic                  m_ovf;
    logic                  m_valid;
    logic                  m_ready;
    logic                  busy;
    logic                  drop_err;

    logic signed [PW-1:0]  p_drv;
    logic signed [PW-1:0]  pv [LAT];
    logic [PW:0]           sb [$];

    int checks = 0;
    int errors = 0;

    dsp_frame_acc #(
        .P_WIDTH(PW), .LATENCY(LAT), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .p(p), .frame_len(frame_len),
        .m_data(m_data), .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: operand value emerges LAT cycles after issue; junk otherwise.
    always @(posedge clk) begin
        pv[0] <= issue ? p_drv : JUNK;
        for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
    end
    assign p = pv[LAT-1];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted output is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h with nothing expected", m_data);
            end else begin
                logic [PW:0] e;
                e = sb.pop_front();
                chk("sb_data", m_data, e[PW-1:0]);
                chk("sb_ovf", PW'(m_ovf), PW'(e[PW]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [PW-1:0] v);
        issue = 1'b1;
        p_drv = v;
        tick();
        issue = 1'b0;
        p_drv = '0;
    endtask

    task automatic expect_out(input logic signed [PW-1:0] d, input logic o);
        sb.push_back({o, d});
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        m_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk({nm, "_drained"}, PW'(sb.size()), '0);
        chk({nm, "_empty"}, PW'(m_valid), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; issue = 1'b0; p_drv = '0; frame_len = 8'd1; m_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", PW'(m_valid), '0);
        chk("rst_data", m_data, '0);
        chk("rst_ovf", PW'(m_ovf), '0);
        chk("rst_busy", PW'(busy), '0);
        chk("rst_drop", PW'(drop_err), '0);
        rst_n = 1'b1;
        tick();

        // Basic frame with latency check: 10 + 20 - 5 = 25.
        frame_len = 8'd3;
        expect_out(48'sd25, 1'b0);
        send(48'sd10); send(48'sd20); send(-48'sd5);
        chk("basic_busy", PW'(busy), 48'd1);
        repeat (LAT - 1) tick();
        chk("lat_early", PW'(m_valid), '0);
        tick();
        chk("lat_valid", PW'(m_valid), 48'd1);
        drain("basic");

        // Length 0 behaves as length 1.
        frame_len = 8'd0;
        expect_out(48'sd7, 1'b0);
        expect_out(-48'sd9, 1'b0);
        send(48'sd7); send(-48'sd9);
        drain("len0");

        // Saturation both rails, flag clears on the next frame.
        frame_len = 8'd2;
        expect_out(PMAX, 1'b1);
        expect_out(48'sd2, 1'b0);
        expect_out(PMIN, 1'b1);
        send(PMAX); send(48'sd5);
        send(48'sd1); send(48'sd1);
        send(PMIN); send(-48'sd1);
        drain("sat");

        // Backpressure: five single-sample frames, only four fit.
        m_ready = 1'b0;
        frame_len = 8'd1;
        for (int i = 1; i <= 4; i++) expect_out(PW'(i), 1'b0);
        for (int i = 1; i <= 5; i++) send(PW'(i));
        repeat (LAT + 1) tick();
        chk("bp_drop", PW'(drop_err), 48'd1);
        chk("bp_valid", PW'(m_valid), 48'd1);
        chk("bp_head", m_data, 48'd1);
        tick();
        chk("bp_head_stable", m_data, 48'd1);
        drain("bp");

        // Full FIFO with push and pop on the same edge: no drop.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("clr_drop", PW'(drop_err), '0);
        m_ready = 1'b0;
        for (int i = 11; i <= 15; i++) expect_out(PW'(i), 1'b0);
        for (int i = 11; i <= 14; i++) send(PW'(i));
        send(48'sd15);
        repeat (LAT - 1) tick();
        chk("full_before", PW'(m_data), 48'd11);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("pp_no_drop", PW'(drop_err), '0);
        chk("pp_head", m_data, 48'd12);
        drain("pp");
        chk("pp_drop_final", PW'(drop_err), '0);

        // Length locked mid-frame, then reset with issues in flight.
        frame_len = 8'd4;
        send(48'sd100); send(48'sd200);
        repeat (LAT) tick();
        frame_len = 8'd2;
        send(48'sd300);
        repeat (LAT + 1) tick();
        chk("len_locked", PW'(m_valid), '0);
        chk("len_busy", PW'(busy), 48'd1);
        send(48'sd1000); send(48'sd2000);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", PW'(m_valid), '0);
        chk("mr_busy", PW'(busy), '0);
        tick();
        rst_n = 1'b1;
        repeat (LAT + 2) tick();
        chk("mr_no_stale_busy", PW'(busy), '0);
        chk("mr_no_stale_valid", PW'(m_valid), '0);
        expect_out(48'sd3, 1'b0);
        send(48'sd1); send(48'sd2);
        drain("clean");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
